// File: rtl/btc_miner_pkg.sv
// Shared types and helpers for the mining-job scheduler and its found-nonce FIFO.
package btc_miner_pkg;

  localparam int NONCE_W = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, ADVANCE} sched_state_e;

  // Last nonce of the chunk starting at cursor; 33-bit math so the clamp never wraps.
  function automatic logic [NONCE_W-1:0] chunk_end(
    input logic [NONCE_W-1:0] cursor,
    input logic [NONCE_W-1:0] job_last,
    input logic               wraps,
    input int unsigned        log2
  );
    logic [NONCE_W:0] span_end;
    logic [NONCE_W:0] target;
    span_end = {1'b0, cursor} + ((33'd1 << log2) - 33'd1);
    target   = (wraps && (cursor > job_last)) ? {1'b0, {NONCE_W{1'b1}}} : {1'b0, job_last};
    return (span_end < target) ? span_end[NONCE_W-1:0] : target[NONCE_W-1:0];
  endfunction

endpackage

// File: rtl/btc_miner_job_sched_fifo.sv
// Synchronous first-word-fall-through FIFO holding nonces reported by the core.
module btc_nonce_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A same-cycle pop frees the head slot, so a push while full still lands.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/btc_miner_job_sched.sv
// Splits a host nonce range into fixed-size chunks, runs the core once per chunk,
// and collects found nonces in a small FIFO with timeout/overflow status.
module btc_miner_job_sched
  import btc_miner_pkg::*;
#(
  parameter int unsigned CHUNK_LOG2  = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 2**20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               job_valid,
  output logic               job_ready,
  input  logic [NONCE_W-1:0] job_nonce_first,
  input  logic [NONCE_W-1:0] job_nonce_last,
  input  logic               job_abort,
  output logic               core_start,
  output logic [NONCE_W-1:0] core_nonce_base,
  output logic [NONCE_W-1:0] core_nonce_last,
  output logic               core_abort,
  input  logic               core_done,
  input  logic               core_found,
  input  logic [NONCE_W-1:0] core_found_nonce,
  output logic               fifo_valid,
  output logic [NONCE_W-1:0] fifo_nonce,
  input  logic               fifo_pop,
  output logic               busy,
  output logic [31:0]        chunk_count,
  output logic               sts_timeout,
  output logic               sts_overflow
);

  sched_state_e       state_q, state_d;
  logic [NONCE_W-1:0] job_last_q, job_last_d;
  logic [NONCE_W-1:0] cursor_q, cursor_d;
  logic [NONCE_W-1:0] base_q, base_d;
  logic [NONCE_W-1:0] clast_q, clast_d;
  logic [31:0]        chunk_count_q, chunk_count_d;
  logic [31:0]        wd_q, wd_d;
  logic               wraps_q, wraps_d;
  logic               job_ready_q, job_ready_d;
  logic               core_start_q, core_start_d;
  logic               core_abort_q, core_abort_d;
  logic               busy_q, busy_d;
  logic               sts_timeout_q, sts_timeout_d;
  logic               sts_overflow_q, sts_overflow_d;
  logic               fifo_full, fifo_empty;
  logic               overflow_evt;
  logic [NONCE_W-1:0] next_cursor;

  btc_nonce_fifo #(.WIDTH(NONCE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (core_found),
    .push_data (core_found_nonce),
    .pop       (fifo_pop),
    .rd_data   (fifo_nonce),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign overflow_evt = core_found && fifo_full && !fifo_pop;
  assign next_cursor  = clast_q + 32'd1;

  always_comb begin
    state_d        = state_q;
    job_last_d     = job_last_q;
    cursor_d       = cursor_q;
    base_d         = base_q;
    clast_d        = clast_q;
    chunk_count_d  = chunk_count_q;
    wd_d           = wd_q;
    wraps_d        = wraps_q;
    job_ready_d    = 1'b0;
    core_start_d   = 1'b0;
    core_abort_d   = 1'b0;
    sts_timeout_d  = sts_timeout_q;
    sts_overflow_d = sts_overflow_q | overflow_evt;
    case (state_q)
      IDLE: begin
        // job_ready rises one cycle after IDLE is entered, giving the host a settled view.
        job_ready_d = 1'b1;
        if (job_valid && job_ready_q) begin
          job_ready_d    = 1'b0;
          job_last_d     = job_nonce_last;
          wraps_d        = job_nonce_first > job_nonce_last;
          cursor_d       = job_nonce_first;
          base_d         = job_nonce_first;
          clast_d        = chunk_end(job_nonce_first, job_nonce_last,
                                     job_nonce_first > job_nonce_last, CHUNK_LOG2);
          chunk_count_d  = '0;
          sts_timeout_d  = 1'b0;
          sts_overflow_d = overflow_evt;
          core_start_d   = 1'b1;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = 32'd1;
        state_d = job_abort ? IDLE : RUN;
      end
      RUN: begin
        if (job_abort) begin
          core_abort_d = 1'b1;
          state_d      = IDLE;
        end else if (core_done) begin
          state_d = ADVANCE;
        end else if ((TIMEOUT_CYC != 0) && (wd_q >= 32'(TIMEOUT_CYC - 1))) begin
          core_abort_d  = 1'b1;
          sts_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          wd_d = wd_q + 32'd1;
        end
      end
      ADVANCE: begin
        chunk_count_d = chunk_count_q + 32'd1;
        if (job_abort || (clast_q == job_last_q)) begin
          state_d = IDLE;
        end else begin
          cursor_d     = next_cursor;
          base_d       = next_cursor;
          clast_d      = chunk_end(next_cursor, job_last_q, wraps_q, CHUNK_LOG2);
          core_start_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      job_last_q     <= '0;
      cursor_q       <= '0;
      base_q         <= '0;
      clast_q        <= '0;
      chunk_count_q  <= '0;
      wd_q           <= '0;
      wraps_q        <= 1'b0;
      job_ready_q    <= 1'b1;
      core_start_q   <= 1'b0;
      core_abort_q   <= 1'b0;
      busy_q         <= 1'b0;
      sts_timeout_q  <= 1'b0;
      sts_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      job_last_q     <= job_last_d;
      cursor_q       <= cursor_d;
      base_q         <= base_d;
      clast_q        <= clast_d;
      chunk_count_q  <= chunk_count_d;
      wd_q           <= wd_d;
      wraps_q        <= wraps_d;
      job_ready_q    <= job_ready_d;
      core_start_q   <= core_start_d;
      core_abort_q   <= core_abort_d;
      busy_q         <= busy_d;
      sts_timeout_q  <= sts_timeout_d;
      sts_overflow_q <= sts_overflow_d;
    end
  end

  assign job_ready       = job_ready_q;
  assign core_start      = core_start_q;
  assign core_nonce_base = base_q;
  assign core_nonce_last = clast_q;
  assign core_abort      = core_abort_q;
  assign busy            = busy_q;
  assign chunk_count     = chunk_count_q;
  assign sts_timeout     = sts_timeout_q;
  assign sts_overflow    = sts_overflow_q;
  assign fifo_valid      = !fifo_empty;

endmodule

// File: tb/tb_btc_miner_job_sched.sv
// Bench for the job scheduler: table-driven jobs, FIFO/timeout/abort/reset
// sequences, and randomized jobs checked against a range-arithmetic model.
module tb_btc_miner_job_sched;

  localparam int unsigned CHUNK = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready, job_abort;
  logic [31:0] job_nonce_first, job_nonce_last;
  logic        core_start, core_abort, core_done, core_found;
  logic [31:0] core_nonce_base, core_nonce_last, core_found_nonce;
  logic        fifo_valid, fifo_pop, busy, sts_timeout, sts_overflow;
  logic [31:0] fifo_nonce, chunk_count;

  int          vecCount = 0;
  int          errCount = 0;
  logic [31:0] fifoQ[$];
  bit          ovfModel;

  typedef struct {
    logic [31:0] first;
    logic [31:0] last;
    int          nChunks;
    logic [31:0] finalBase;
    logic [31:0] finalEnd;
  } jobVec_t;

  jobVec_t vecs[8];

  btc_miner_job_sched #(.CHUNK_LOG2(4), .FIFO_DEPTH(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_nonce_first(job_nonce_first), .job_nonce_last(job_nonce_last),
    .job_abort(job_abort),
    .core_start(core_start), .core_nonce_base(core_nonce_base),
    .core_nonce_last(core_nonce_last), .core_abort(core_abort),
    .core_done(core_done), .core_found(core_found), .core_found_nonce(core_found_nonce),
    .fifo_valid(fifo_valid), .fifo_nonce(fifo_nonce), .fifo_pop(fifo_pop),
    .busy(busy), .chunk_count(chunk_count),
    .sts_timeout(sts_timeout), .sts_overflow(sts_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Runs one job with a responsive core; chunks are predicted from range arithmetic.
  task automatic applyStimulus(input logic [31:0] first, input logic [31:0] last,
                               input int doneDelay, input bit fifoTraffic,
                               output int starts, output logic [31:0] lastBase,
                               output logic [31:0] lastEnd);
    logic [31:0]     expBase[$];
    logic [31:0]     expEnd[$];
    longint unsigned pos, stopPos, segEnd, e;
    int              cnt, cyc, doneCyc, w;
    bit              popOk, finished;
    pos     = {32'b0, first};
    stopPos = (first > last) ? ({32'b0, last} + 64'h1_0000_0000) : {32'b0, last};
    while (pos <= stopPos) begin
      segEnd = (pos <= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : stopPos;
      if (segEnd > stopPos) segEnd = stopPos;
      e = pos + CHUNK - 1;
      if (e > segEnd) e = segEnd;
      expBase.push_back(32'(pos));
      expEnd.push_back(32'(e));
      pos = e + 1;
    end
    starts = 0; lastBase = '0; lastEnd = '0; cnt = 0; doneCyc = 0; ovfModel = 0; finished = 0;
    w = 0;
    while (!job_ready && w < 20) begin tick(); w++; end
    checkOutput("jobReadyBeforeAccept", job_ready, 1);
    job_nonce_first = first; job_nonce_last = last; job_valid = 1;
    tick();
    job_valid = 0;
    for (cyc = 1; cyc < 4000; cyc++) begin
      core_done = 0; core_found = 0; fifo_pop = 0;
      if (fifoTraffic) begin
        checkOutput("fifoValid", fifo_valid, fifoQ.size() != 0);
        if (fifoQ.size() != 0) checkOutput("fifoHead", fifo_nonce, fifoQ[0]);
      end
      if (!busy) begin finished = 1; break; end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin core_done = 1; doneCyc = cyc; end
      end
      if (core_start) begin
        if (starts < expBase.size()) begin
          checkOutput("chunkBase", core_nonce_base, expBase[starts]);
          checkOutput("chunkLast", core_nonce_last, expEnd[starts]);
        end else begin
          checkOutput("extraChunk", starts, expBase.size());
        end
        if (starts == 0) checkOutput("acceptToStart", cyc, 1);
        else             checkOutput("doneToStart", cyc - doneCyc, 2);
        lastBase = core_nonce_base; lastEnd = core_nonce_last;
        starts++;
        cnt = (doneDelay > 0) ? doneDelay : $urandom_range(1, 8);
      end
      if (fifoTraffic) begin
        core_found       = ($urandom_range(0, 3) == 0);
        core_found_nonce = $urandom;
        fifo_pop         = ($urandom_range(0, 2) == 0);
        popOk = fifo_pop && (fifoQ.size() != 0);
        if (core_found && fifoQ.size() == 4 && !popOk) ovfModel = 1;
        if (popOk) void'(fifoQ.pop_front());
        if (core_found && fifoQ.size() < 4) fifoQ.push_back(core_found_nonce);
      end
      tick();
    end
    core_done = 0; core_found = 0; fifo_pop = 0;
    checkOutput("jobFinished", finished, 1);
    if (finished) begin
      checkOutput("doneToIdle", cyc - doneCyc, 2);
      w = 0;
      while (!job_ready && w < 10) begin tick(); w++; end
      checkOutput("doneToReady", cyc + w - doneCyc, 3);
    end
    checkOutput("chunkStarts", starts, expBase.size());
    checkOutput("chunkCount", chunk_count, expBase.size());
    checkOutput("stsOverflow", sts_overflow, ovfModel);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL globalTimeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int          starts, n;
    logic [31:0] lb, le, first, last;
    logic [31:0] drainExp[4];

    vecs[0] = '{32'h0000_0100, 32'h0000_012F, 3, 32'h0000_0120, 32'h0000_012F};
    vecs[1] = '{32'h0000_0105, 32'h0000_0107, 1, 32'h0000_0105, 32'h0000_0107};
    vecs[2] = '{32'hFFFF_FFF8, 32'h0000_0007, 2, 32'h0000_0000, 32'h0000_0007};
    vecs[3] = '{32'hFFFF_FFFA, 32'h0000_0015, 3, 32'h0000_0010, 32'h0000_0015};
    vecs[4] = '{32'h0000_0003, 32'h0000_0024, 3, 32'h0000_0023, 32'h0000_0024};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
    vecs[7] = '{32'h7FFF_FFFF, 32'h8000_0010, 2, 32'h8000_000F, 32'h8000_0010};
    drainExp = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0005};

    rst = 1; job_valid = 0; job_abort = 0; core_done = 0; core_found = 0;
    fifo_pop = 0; job_nonce_first = 0; job_nonce_last = 0; core_found_nonce = 0;
    tick(); tick();
    rst = 0;
    checkOutput("rstJobReady", job_ready, 1);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstCoreStart", core_start, 0);
    checkOutput("rstCoreAbort", core_abort, 0);
    checkOutput("rstChunkCount", chunk_count, 0);
    checkOutput("rstFifoValid", fifo_valid, 0);
    checkOutput("rstStsTimeout", sts_timeout, 0);
    checkOutput("rstStsOverflow", sts_overflow, 0);

    // Five finds with no pop: first four kept, fifth dropped with overflow.
    for (int i = 0; i < 5; i++) begin
      core_found = 1; core_found_nonce = 32'hA000_0000 + i;
      tick();
    end
    core_found = 0;
    checkOutput("ovfFifoValid", fifo_valid, 1);
    checkOutput("ovfHead", fifo_nonce, 32'hA000_0000);
    checkOutput("ovfSticky", sts_overflow, 1);
    job_nonce_first = 32'h10; job_nonce_last = 32'h10; job_valid = 1;
    tick();
    job_valid = 0; job_abort = 1;
    tick();
    job_abort = 0;
    tick(); tick();
    checkOutput("ovfClearedOnAccept", sts_overflow, 0);
    checkOutput("abortInIssueBusy", busy, 0);
    fifo_pop = 1; core_found = 1; core_found_nonce = 32'hA000_0005;
    tick();
    fifo_pop = 0; core_found = 0;
    checkOutput("pushPopFullNoOvf", sts_overflow, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drainValid", fifo_valid, 1);
      checkOutput("drainHead", fifo_nonce, drainExp[i]);
      fifo_pop = 1; tick(); fifo_pop = 0;
    end
    checkOutput("drainEmpty", fifo_valid, 0);
    fifo_pop = 1; tick(); fifo_pop = 0;
    checkOutput("popEmptyNoEffect", fifo_valid, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].first, vecs[i].last, 5, 0, starts, lb, le);
      checkOutput("tblChunks", starts, vecs[i].nChunks);
      checkOutput("tblFinalBase", lb, vecs[i].finalBase);
      checkOutput("tblFinalEnd", le, vecs[i].finalEnd);
      checkOutput("tblBusyLow", busy, 0);
    end

    // Core never finishes: watchdog aborts 64 cycles after core_start.
    job_nonce_first = 32'h0; job_nonce_last = 32'hFF; job_valid = 1;
    tick();
    job_valid = 0;
    checkOutput("toStart", core_start, 1);
    n = 0;
    while (n < 200) begin
      tick(); n++;
      if (core_abort) break;
    end
    checkOutput("toAbortCycle", n, 64);
    checkOutput("toSticky", sts_timeout, 1);
    checkOutput("toBusy", busy, 0);
    tick();
    checkOutput("toAbortPulse", core_abort, 0);
    tick();

    // job_abort and core_done together in RUN: abort wins, no chunk credited.
    job_nonce_first = 32'h100; job_nonce_last = 32'h12F; job_valid = 1;
    tick();
    job_valid = 0;
    tick(); tick(); tick(); tick();
    core_done = 1; tick(); core_done = 0;
    tick(); tick();
    checkOutput("abDoneSecondBase", core_nonce_base, 32'h110);
    checkOutput("abDoneCount1", chunk_count, 1);
    checkOutput("abDoneTimeoutCleared", sts_timeout, 0);
    job_abort = 1; core_done = 1;
    tick();
    job_abort = 0; core_done = 0;
    checkOutput("abDoneCoreAbort", core_abort, 1);
    checkOutput("abDoneBusy", busy, 0);
    checkOutput("abDoneCountKept", chunk_count, 1);

    for (int j = 0; j < 12; j++) begin
      first = ($urandom_range(0, 1) == 1) ? 32'(32'hFFFF_FFFF - $urandom_range(0, 40)) : 32'($urandom);
      last  = first + 32'($urandom_range(0, 70));
      applyStimulus(first, last, 0, 1, starts, lb, le);
      checkOutput("rndFinalEnd", le, last);
    end
    while (fifoQ.size() != 0) begin
      checkOutput("rndDrainHead", fifo_nonce, fifoQ[0]);
      void'(fifoQ.pop_front());
      fifo_pop = 1; tick(); fifo_pop = 0;
    end
    checkOutput("rndDrainEmpty", fifo_valid, 0);

    // Reset in the middle of a run clears everything, FIFO included.
    tick(); tick();
    job_nonce_first = 32'h200; job_nonce_last = 32'h2FF; job_valid = 1;
    tick();
    job_valid = 0;
    tick();
    core_found = 1; core_found_nonce = 32'h1234; tick(); core_found = 0;
    checkOutput("midRunFifoValid", fifo_valid, 1);
    checkOutput("midRunBusy", busy, 1);
    rst = 1; tick(); rst = 0;
    checkOutput("midRstJobReady", job_ready, 1);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstFifoValid", fifo_valid, 0);
    checkOutput("midRstFifoNonce", fifo_nonce, 0);
    checkOutput("midRstBase", core_nonce_base, 0);
    checkOutput("midRstLast", core_nonce_last, 0);
    checkOutput("midRstCount", chunk_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
